// File: rtl/nec_multiplier.sv
// Sequential shift-add multiplier for MUL/IMUL: wide (WIDTH x WIDTH) or byte (WIDTH/2 x WIDTH/2),
// signed or unsigned, one product bit per clock-enabled cycle, with overflow for CY/OV.
//
// state | meaning
// IDLE  | no operation in flight; result/overflow hold last completed product
// RUN   | shift-add iterations in progress, one per ce edge
module nec_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               start,
  input  logic               wide,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [2*WIDTH-1:0] result
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_finish;

  logic               r_wide;
  logic               r_signed;
  logic               r_neg;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH:0]     r_acc;
  logic [CW-1:0]      r_count;
  logic               r_done;
  logic               r_overflow;
  logic [2*WIDTH-1:0] r_result;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_nxt;
  logic [WIDTH-1:0]   w_mcand_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res_nxt;
  logic               w_ov_nxt;

  // Operand magnitudes in the selected width; the most-negative value maps onto itself as unsigned.
  always_comb begin
    w_a_neg = is_signed & (wide ? a[WIDTH-1] : a[HALF-1]);
    w_b_neg = is_signed & (wide ? b[WIDTH-1] : b[HALF-1]);
    if (wide) begin
      w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
      w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;
    end else begin
      w_a_mag = {{HALF{1'b0}}, (w_a_neg ? (~a[HALF-1:0] + HALF'(1)) : a[HALF-1:0])};
      w_b_mag = {{HALF{1'b0}}, (w_b_neg ? (~b[HALF-1:0] + HALF'(1)) : b[HALF-1:0])};
    end
  end

  assign w_last = r_wide ? (r_count == CW'(WIDTH - 1)) : (r_count == CW'(HALF - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    if (ce) begin
      if (start) begin
        w_load      = 1'b1;
        w_state_nxt = RUN;
      end else if (r_state == RUN) begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // One shift-add step; the final step's outcome feeds the result directly.
  always_comb begin
    w_addend  = r_mcand[0] ? r_mplier : '0;
    w_sum     = r_acc + {1'b0, w_addend};
    w_acc_nxt = {1'b0, w_sum[WIDTH:1]};
    if (r_wide) w_mcand_nxt = {w_sum[0], r_mcand[WIDTH-1:1]};
    else        w_mcand_nxt = {{HALF{1'b0}}, w_sum[0], r_mcand[HALF-1:1]};
  end

  always_comb begin
    if (r_wide) begin
      w_prod    = {w_acc_nxt[WIDTH-1:0], w_mcand_nxt};
      w_res_nxt = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
      if (r_signed) w_ov_nxt = (w_res_nxt[2*WIDTH-1:WIDTH] != {WIDTH{w_res_nxt[WIDTH-1]}});
      else          w_ov_nxt = |w_res_nxt[2*WIDTH-1:WIDTH];
    end else begin
      w_prod    = {{WIDTH{1'b0}}, w_acc_nxt[HALF-1:0], w_mcand_nxt[HALF-1:0]};
      w_res_nxt = {{WIDTH{1'b0}}, (r_neg ? (~w_prod[WIDTH-1:0] + WIDTH'(1)) : w_prod[WIDTH-1:0])};
      if (r_signed) w_ov_nxt = (w_res_nxt[WIDTH-1:HALF] != {HALF{w_res_nxt[HALF-1]}});
      else          w_ov_nxt = |w_res_nxt[WIDTH-1:HALF];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wide     <= 1'b0;
      r_signed   <= 1'b0;
      r_neg      <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_result   <= '0;
    end else if (ce) begin
      r_done <= 1'b0;
      if (w_load) begin
        r_wide     <= wide;
        r_signed   <= is_signed;
        r_neg      <= w_a_neg ^ w_b_neg;
        r_mcand    <= w_a_mag;
        r_mplier   <= w_b_mag;
        r_acc      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_step) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= w_mcand_nxt;
        r_count <= r_count + CW'(1);
        if (w_finish) begin
          r_done     <= 1'b1;
          r_result   <= w_res_nxt;
          r_overflow <= w_ov_nxt;
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign result   = r_result;

endmodule
